// File: rtl/sseg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// The optional dimming feature is enabled with the SSEG_DIM_EN macro.
package sseg_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [7:0] seg_t;

  localparam seg_t       SEG_BLANK = 8'hFF;
  localparam logic [3:0] LDSEL_OFF = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } state_e;

  // Active-low digit select: only the addressed digit is pulled low.
  function automatic logic [3:0] ldsel_for(input logic [1:0] idx);
    logic [3:0] sel;
    sel      = LDSEL_OFF;
    sel[idx] = 1'b0;
    return sel;
  endfunction

endpackage

// File: rtl/sseg_frame_buf.sv
// Pending/shadow double buffer: a frame is taken in over a valid/ready port and
// copied to the displayed shadow copy only when the scan logic strobes commit_i.
module sseg_frame_buf
  import sseg_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] seg_n_i [NUM_DIGITS-1:0],
  input  logic       load_i,
  output logic       rdy_o,
  input  logic       commit_i,
  input  logic [1:0] rd_idx_i,
  output logic [7:0] rd_seg_o
);

  logic [7:0] pend_q   [NUM_DIGITS-1:0];
  logic [7:0] shadow_q [NUM_DIGITS-1:0];
  logic       pend_full_q;
  logic       accept;
  logic       take;

  assign rdy_o  = !pend_full_q;
  assign accept = load_i && !pend_full_q;
  // A load and a commit are mutually exclusive: one needs the flag clear, the other set.
  assign take   = commit_i && pend_full_q;

  always_ff @(posedge clk_i) begin
    if (accept) begin
      pend_q <= seg_n_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_full_q <= 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        shadow_q[k] <= SEG_BLANK;
      end
    end else begin
      if (accept) begin
        pend_full_q <= 1'b1;
      end else if (take) begin
        pend_full_q <= 1'b0;
      end
      if (take) begin
        shadow_q <= pend_q;
      end
    end
  end

  assign rd_seg_o = shadow_q[rd_idx_i];

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Four-digit seven-segment scan scheduler with per-slot blanking and
// frame-synchronous double-buffered updates; SSEG_DIM_EN adds PWM dimming.
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int SLOT_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_en,
  input  logic [7:0] i_seg_n [3:0],
  input  logic       i_load,
  output logic       o_load_rdy,
`ifdef SSEG_DIM_EN
  input  logic [3:0] i_bright,
`endif
  output logic [7:0] o_sseg_n,
  output logic [3:0] o_ldsel,
  output logic       o_frame_start
);

  localparam int              CNT_W      = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [7:0]       sseg_q, sseg_d;
  logic [3:0]       ldsel_q, ldsel_d;
  logic             fs_q, fs_d;
  logic             boundary;
  logic             commit;
  logic [7:0]       shadow_seg;
  logic             lit;

  // Last cycle of slot 3 is always in DRIVE because BLANK_CYCLES < SLOT_CYCLES.
  assign boundary = (state_q == ST_DRIVE) && (cnt_q == CNT_LAST) && (idx_q == 2'd3);
  assign commit   = boundary || (state_q == ST_IDLE);

  sseg_frame_buf u_frame_buf (
    .clk_i    (i_clk),
    .rst_ni   (i_reset_n),
    .seg_n_i  (i_seg_n),
    .load_i   (i_load),
    .rdy_o    (o_load_rdy),
    .commit_i (commit),
    .rd_idx_i (idx_q),
    .rd_seg_o (shadow_seg)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (i_en) begin
          state_d = ST_BLANK;
        end
      end
      ST_BLANK: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == BLANK_LAST) begin
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          idx_d   = idx_q + 1'b1;
          state_d = ST_BLANK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
    // Disable overrides everything so re-enable always restarts at digit 0.
    if (!i_en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end
  end

`ifdef SSEG_DIM_EN
  logic [3:0] bright_q;
  logic [3:0] pwm_q, pwm_d;

  always_comb begin
    pwm_d = pwm_q;
    if ((state_q == ST_BLANK) && (cnt_q == BLANK_LAST)) begin
      pwm_d = '0;
    end else if (state_q == ST_DRIVE) begin
      pwm_d = pwm_q + 1'b1;
    end
  end

  assign lit = (pwm_q <= bright_q);

  // Brightness only changes at frame granularity so a frame is never mixed.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      bright_q <= 4'hF;
      pwm_q    <= '0;
    end else begin
      pwm_q <= pwm_d;
      if (boundary || ((state_q == ST_IDLE) && i_en)) begin
        bright_q <= i_bright;
      end
    end
  end
`else
  assign lit = 1'b1;
`endif

  always_comb begin
    sseg_d  = SEG_BLANK;
    ldsel_d = LDSEL_OFF;
    if ((state_q == ST_DRIVE) && lit) begin
      sseg_d  = shadow_seg;
      ldsel_d = ldsel_for(idx_q);
    end
    fs_d = (state_q == ST_BLANK) && (cnt_q == '0) && (idx_q == 2'd0);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sseg_q  <= SEG_BLANK;
      ldsel_q <= LDSEL_OFF;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sseg_q  <= sseg_d;
      ldsel_q <= ldsel_d;
      fs_q    <= fs_d;
    end
  end

  assign o_sseg_n      = sseg_q;
  assign o_ldsel       = ldsel_q;
  assign o_frame_start = fs_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Scoreboard bench for sseg_scan_ctrl: a frame-position reference model predicts
// every registered output cycle; a monitor pops and compares on the falling edge.
module tb_sseg_scan_ctrl;

  localparam int SLOT  = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 4 * SLOT;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       en    = 1'b0;
  logic       load  = 1'b0;
  logic [7:0] seg [3:0];
  logic       rdy;
  logic [7:0] sseg;
  logic [3:0] ldsel;
  logic       fs;
`ifdef SSEG_DIM_EN
  logic [3:0] bright = 4'd15;
`endif

  always #5 clk = ~clk;

  sseg_scan_ctrl #(.SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK)) dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_en          (en),
    .i_seg_n       (seg),
    .i_load        (load),
    .o_load_rdy    (rdy),
`ifdef SSEG_DIM_EN
    .i_bright      (bright),
`endif
    .o_sseg_n      (sseg),
    .o_ldsel       (ldsel),
    .o_frame_start (fs)
  );

  typedef struct packed {
    logic [7:0] sseg;
    logic [3:0] ldsel;
    logic       fs;
    logic       rdy;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: the scan is just a position within a 4*SLOT frame.
  bit         m_run   = 1'b0;
  int         m_pos   = 0;
  bit         m_pfull = 1'b0;
  logic [7:0] m_shadow [4];
  logic [7:0] m_pend   [4];
  int         m_bright = 15;

  function automatic bit lit_model(int drive_off);
`ifdef SSEG_DIM_EN
    return (drive_off % 16) <= m_bright;
`else
    return (drive_off >= 0);
`endif
  endfunction

  always @(posedge clk) begin
    exp_t e;
    bit   pf0;
    int   slot;
    int   off;
    if (!rst_n) begin
      m_run   = 1'b0;
      m_pos   = 0;
      m_pfull = 1'b0;
      m_bright = 15;
      for (int k = 0; k < 4; k++) m_shadow[k] = 8'hFF;
      e.sseg = 8'hFF; e.ldsel = 4'hF; e.fs = 1'b0; e.rdy = 1'b1;
      sb_q.push_back(e);
    end else begin
      pf0     = m_pfull;
      e.sseg  = 8'hFF;
      e.ldsel = 4'hF;
      e.fs    = 1'b0;
      if (m_run) begin
        slot = m_pos / SLOT;
        off  = m_pos % SLOT;
        e.fs = (m_pos == 0);
        if (off >= BLANK && lit_model(off - BLANK)) begin
          e.sseg        = m_shadow[slot];
          e.ldsel[slot] = 1'b0;
        end
        if (m_pos == FRAME - 1) begin
          if (pf0) begin
            m_shadow = m_pend;
            m_pfull  = 1'b0;
          end
`ifdef SSEG_DIM_EN
          m_bright = int'(bright);
`endif
        end
        m_pos = (m_pos + 1) % FRAME;
        if (!en) begin
          m_run = 1'b0;
          m_pos = 0;
        end
      end else begin
        if (pf0) begin
          m_shadow = m_pend;
          m_pfull  = 1'b0;
        end
        if (en) begin
          m_run = 1'b1;
          m_pos = 0;
`ifdef SSEG_DIM_EN
          m_bright = int'(bright);
`endif
        end
      end
      if (load && !pf0) begin
        for (int k = 0; k < 4; k++) m_pend[k] = seg[k];
        m_pfull = 1'b1;
      end
      e.rdy = !m_pfull;
      sb_q.push_back(e);
    end
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at %0t: got %02h expected %02h", nm, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("sseg_n", sseg, e.sseg);
      chk("ldsel", {4'h0, ldsel}, {4'h0, e.ldsel});
      chk("frame_start", {7'h0, fs}, {7'h0, e.fs});
      chk("load_rdy", {7'h0, rdy}, {7'h0, e.rdy});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_pos(input int p);
    int guard;
    guard = 0;
    while (!(m_run && m_pos == p)) begin
      tick(1);
      guard++;
      if (guard > 4 * FRAME) begin
        n_cmp++;
        n_bad++;
        $display("FAIL wait_pos(%0d) timeout: pos %0d run %0d", p, m_pos, m_run);
        return;
      end
    end
  endtask

  task automatic rand_seg();
    for (int k = 0; k < 4; k++) seg[k] = 8'($urandom);
  endtask

  initial begin
    for (int k = 0; k < 4; k++) seg[k] = 8'h00;
    #2 rst_n = 1'b0;
    tick(3);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(3);

    // Enable with nothing loaded: digit walk, blank segments.
    en = 1'b1;
    tick(2 * FRAME + 4);

    // Mid-frame load, committed at the next boundary.
    wait_pos(10);
    seg[0] = 8'hC0; seg[1] = 8'hF9; seg[2] = 8'hA4; seg[3] = 8'hB0;
    load = 1'b1;
    tick(1);
    load = 1'b0;
    tick(FRAME + 10);

    // Back-pressure: load held while data keeps changing.
    wait_pos(5);
    load = 1'b1;
    for (int c = 0; c < 2 * FRAME + 6; c++) begin
      rand_seg();
      tick(1);
    end
    load = 1'b0;
    tick(FRAME + 2);

    // Load on the boundary cycle itself.
    wait_pos(FRAME - 1);
    rand_seg();
    load = 1'b1;
    tick(1);
    load = 1'b0;
    tick(2 * FRAME + 2);

    // Disable during digit 2 DRIVE, load while idle, re-enable.
    wait_pos(2 * SLOT + 4);
    en = 1'b0;
    tick(4);
    rand_seg();
    load = 1'b1;
    tick(1);
    load = 1'b0;
    tick(3);
    en = 1'b1;
    tick(FRAME + 4);

`ifdef SSEG_DIM_EN
    bright = 4'd3;
    tick(2 * FRAME);
    wait_pos(12);
    bright = 4'd15;
    tick(2 * FRAME);
    bright = 4'd0;
    tick(2 * FRAME);
`endif

    // Randomized traffic.
    for (int c = 0; c < 800; c++) begin
      en   = ($urandom_range(0, 59) != 0);
      load = ($urandom_range(0, 7) == 0);
      rand_seg();
`ifdef SSEG_DIM_EN
      if ($urandom_range(0, 49) == 0) bright = 4'($urandom);
`endif
      tick(1);
    end
    load = 1'b0;
    en   = 1'b0;
    tick(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sseg_scan_ctrl.md
# sseg_scan_ctrl

Scan scheduler for the 4-digit seven-segment display. It time-shares the single segment bus between the four digits and inserts a blanking gap at every digit change to prevent ghosting. A whole-frame update arrives through a valid/ready load port, is double-buffered, and is committed only at a frame boundary. It sits between the hex-to-segment decoders and the board pins, and replaces the free-running 4:1 LED mux.

## Interface
- SLOT_CYCLES, 50000: clock cycles per digit slot, including blanking; must be ≥ 2.
- BLANK_CYCLES, 500: blanked cycles at the start of each slot; must satisfy 1 ≤ BLANK_CYCLES < SLOT_CYCLES.
- i_clk  in  1  system clock; all logic runs on its rising edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_en  in  1  scan enable; low means display off.
- i_seg_n  in  4×8 (unpacked [3:0])  frame to load; element k is the active-low pattern for digit k.
- i_load  in  1  load valid.
- o_load_rdy  out  1  pending buffer empty; a load is accepted when `i_load && o_load_rdy`.
- i_bright  in  4  brightness, 0–15; present only with SSEG_DIM_EN.
- o_sseg_n  out  8  active-low segments, registered.
- o_ldsel  out  4  active-low digit select, one-cold or all-high, registered.
- o_frame_start  out  1  one-cycle pulse, registered.

## Operation
- Internal state:
  - shadow frame (displayed);
  - pending frame plus pending_full flag;
  - slot counter: 0..SLOT_CYCLES-1;
  - digit index: 0..3;
  - FSM states IDLE, BLANK, DRIVE.
- IDLE (i_en=0):
  - outputs blank (o_sseg_n=8'hFF, o_ldsel=4'hF);
  - counter=0, index=0;
  - if pending_full, pending→shadow every cycle and pending_full clears.
- IDLE→BLANK on i_en=1, at counter 0, index 0.
- BLANK:
  - outputs blank;
  - → DRIVE when counter reaches BLANK_CYCLES-1.
- DRIVE:
  - o_ldsel bit[index]=0, all other bits 1;
  - o_sseg_n = shadow[index].
- At counter=SLOT_CYCLES-1 the counter wraps to 0, index increments mod 4, and the FSM → BLANK.
- Frame boundary is the last cycle of slot 3. At that cycle, if pending_full (registered value): shadow←pending and pending_full←0.
- Load: when `i_load && o_load_rdy`, pending←i_seg_n and pending_full←1. o_load_rdy = !pending_full, combinational from the flag.
- Load on the boundary cycle itself: captured into pending, committed at the next boundary. A frame never tears mid-scan.
- i_en falls mid-slot: next cycle → IDLE, blank, counters cleared. Re-enable restarts at digit 0 with a full BLANK.
- Reset (asynchronous):
  - shadow=all 8'hFF, pending_full=0, FSM=IDLE, counter=0, index=0;
  - o_sseg_n=8'hFF, o_ldsel=4'hF, o_frame_start=0, o_load_rdy=1.

## Timing
- Outputs lag internal state by exactly one cycle (registered pins).
- Frame period = 4×SLOT_CYCLES cycles. Each digit is driven SLOT_CYCLES−BLANK_CYCLES cycles per frame.
- o_frame_start pulses on the same output cycle as the first blank cycle of slot 0. This includes the first slot after enable.
- Committed frame appears on pins starting at the first DRIVE output of digit 0 after the boundary.
- o_load_rdy returns high the cycle after the commit.
- Counter width = $clog2(SLOT_CYCLES). The counter never exceeds SLOT_CYCLES-1.

## Configuration
- Macro: SSEG_DIM_EN.
- Defined:
  - i_bright exists; it is sampled into a brightness register at each frame boundary and on IDLE→BLANK.
  - A 4-bit PWM counter resets to 0 at entry to DRIVE and increments each DRIVE cycle, wrapping.
  - The digit is lit only while pwm ≤ brightness; otherwise outputs are blank with o_ldsel=4'hF.
  - Brightness 15 = always lit; brightness 0 = 1 of every 16 cycles.
  - Reset value of the brightness register is 15.
- Undefined: no i_bright port and no PWM logic; DRIVE is always lit.

## Structure
- Shared package sseg_pkg:
  - NUM_DIGITS=4;
  - typedef seg_t (logic [7:0]);
  - SEG_BLANK=8'hFF;
  - LDSEL_OFF=4'hF;
  - FSM state enum.
- One sub-module: sseg_frame_buf (pending/shadow double buffer with handshake and commit strobe). The FSM and counters stay in the top.

## Test plan
All scenarios use SLOT_CYCLES=8, BLANK_CYCLES=2.
- Reset and enable: reset, then i_en=1 with nothing loaded → o_ldsel walks 4'b1110, 1101, 1011, 0111 in 6-cycle DRIVE windows, each preceded by 2 cycles of 4'hF. o_sseg_n stays 8'hFF. o_frame_start pulses every 32 cycles.
- Load and commit: load {8'hC0,8'hF9,8'hA4,8'hB0} mid-frame → o_load_rdy drops the next cycle. Old data remains until the boundary. The next digit 0 shows 8'hC0 (element 0); o_load_rdy rises 1 cycle after the boundary.
- Back-pressure: hold i_load with o_load_rdy=0 and change i_seg_n → the second frame is accepted only after the commit; the first frame is displayed intact for one full frame.
- Boundary-cycle load: load on the last cycle of slot 3 → not shown in the next frame; shown in the frame after.
- Disable and re-enable: drop i_en during digit 2 DRIVE → outputs blank the next cycle. Re-enable → o_frame_start pulses and digit 0 is driven after 2 blank cycles.
- Dimming (SSEG_DIM_EN): i_bright=3 → in each DRIVE window the digit is lit for the first 4 cycles and blank for the last 2. i_bright=15 → lit for all 6. A change mid-frame takes effect at the next frame.
